// File: rtl/pmem_line_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one 4x64-bit pmem burst port.
// Define PMEM_ARB_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
module pmem_line_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_line_read,
    input  logic [31:0]  i_line_address,
    output logic [255:0] i_line_rdata,
    output logic         i_line_resp,
    input  logic         d_line_read,
    input  logic         d_line_write,
    input  logic [31:0]  d_line_address,
    input  logic [255:0] d_line_wdata,
    output logic [255:0] d_line_rdata,
    output logic         d_line_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [63:0]  pmem_wdata,
    input  logic [63:0]  pmem_rdata,
    input  logic         pmem_resp
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_I_READ  = 3'd1;
    localparam logic [2:0] S_D_READ  = 3'd2;
    localparam logic [2:0] S_D_WRITE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]   state;
    logic [1:0]   beat;
    logic [26:0]  line_tag;
    logic [255:0] line_buf;
    logic         grant_d;
    logic         cooldown;
    logic         req_i;
    logic         req_d;
    logic         pick_d;
    logic         grant_now;
    logic         addr_unused;

    // Cache-side handshake: a cache raises its request and holds it (with stable
    // address/wdata) until its one-cycle resp, then drops it in the following cycle.
    assign req_i       = i_line_read;
    assign req_d       = d_line_read | d_line_write;
    assign addr_unused = ^{i_line_address[4:0], d_line_address[4:0]};

    // The first IDLE cycle after DONE never grants: the served cache is still
    // dropping its request there, so contention is judged one cycle later.
    assign grant_now = (state == S_IDLE) && !cooldown && (req_i || req_d);

`ifdef PMEM_ARB_RR_EN
    logic last_d;

    assign pick_d = req_d && (!req_i || !last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (grant_now) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = req_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            beat         <= 2'd0;
            line_tag     <= 27'd0;
            line_buf     <= 256'd0;
            grant_d      <= 1'b0;
            cooldown     <= 1'b0;
            i_line_rdata <= 256'd0;
            d_line_rdata <= 256'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    beat     <= 2'd0;
                    cooldown <= 1'b0;
                    if (grant_now) begin
                        grant_d <= pick_d;
                        if (pick_d) begin
                            line_tag <= d_line_address[31:5];
                            if (d_line_write) begin
                                line_buf <= d_line_wdata;
                                state    <= S_D_WRITE;
                            end else begin
                                state <= S_D_READ;
                            end
                        end else begin
                            line_tag <= i_line_address[31:5];
                            state    <= S_I_READ;
                        end
                    end
                end
                S_I_READ, S_D_READ: begin
                    if (pmem_resp) begin
                        line_buf[{beat, 6'd0} +: 64] <= pmem_rdata;
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            state <= S_DONE;
                            // Publish the completed line only now so an aborted
                            // fill never disturbs the cache-visible data.
                            if (state == S_I_READ) begin
                                i_line_rdata <= {pmem_rdata, line_buf[191:0]};
                            end else begin
                                d_line_rdata <= {pmem_rdata, line_buf[191:0]};
                            end
                        end
                    end
                end
                S_D_WRITE: begin
                    if (pmem_resp) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    cooldown <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign pmem_read    = (state == S_I_READ) || (state == S_D_READ);
    assign pmem_write   = (state == S_D_WRITE);
    assign pmem_address = {line_tag, 5'b0};
    assign pmem_wdata   = line_buf[{beat, 6'd0} +: 64];
    assign i_line_resp  = (state == S_DONE) && !grant_d;
    assign d_line_resp  = (state == S_DONE) && grant_d;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for pmem_line_arbiter: cache drivers and a burst memory model feed
// scoreboard queues that negedge monitors pop against the DUT outputs.
module tb_pmem_line_arbiter;

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L2 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                   64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [255:0] L3 = {64'hC0FF_EE00_0000_0033, 64'hC0FF_EE00_0000_0022,
                                   64'hC0FF_EE00_0000_0011, 64'hC0FF_EE00_0000_0000};
    localparam logic [255:0] L4 = {64'h4040_4040_0000_0003, 64'h4040_4040_0000_0002,
                                   64'h4040_4040_0000_0001, 64'h4040_4040_0000_0000};
    localparam logic [255:0] L5 = {64'h5050_5050_0000_0003, 64'h5050_5050_0000_0002,
                                   64'h5050_5050_0000_0001, 64'h5050_5050_0000_0000};
    localparam logic [255:0] L6 = {64'h6060_6060_0000_0003, 64'h6060_6060_0000_0002,
                                   64'h6060_6060_0000_0001, 64'h6060_6060_0000_0000};
    localparam logic [255:0] WD = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                                   64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};

    // clock / reset
    logic         clk = 1'b0;
    logic         rst;
    logic         i_line_read;
    logic [31:0]  i_line_address;
    logic [255:0] i_line_rdata;
    logic         i_line_resp;
    logic         d_line_read;
    logic         d_line_write;
    logic [31:0]  d_line_address;
    logic [255:0] d_line_wdata;
    logic [255:0] d_line_rdata;
    logic         d_line_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata = 64'd0;
    logic         pmem_resp = 1'b0;

    always #5 clk = ~clk;

    pmem_line_arbiter dut (
        .clk(clk), .rst(rst),
        .i_line_read(i_line_read), .i_line_address(i_line_address),
        .i_line_rdata(i_line_rdata), .i_line_resp(i_line_resp),
        .d_line_read(d_line_read), .d_line_write(d_line_write),
        .d_line_address(d_line_address), .d_line_wdata(d_line_wdata),
        .d_line_rdata(d_line_rdata), .d_line_resp(d_line_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // scoreboard state
    int checks = 0;
    int failures = 0;
    logic [256:0] exp_q[$];       // {is_dcache, line seen with resp}
    logic [33:0]  exp_addr_q[$];  // {pmem_write, pmem_read, pmem_address} at burst start
    logic [63:0]  exp_w_q[$];
    logic [255:0] mem_q[$];
    logic [255:0] d_model = 256'd0;
    int mem_delay = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [259:0] got, input logic [259:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // memory model: optional start delay, then four consecutive beats
    logic         mem_active = 1'b0;
    int           mem_wait = 0;
    int           mem_beat = 0;
    logic [255:0] mem_line = 256'd0;

    always begin
        @(posedge clk);
        #1;
        if (!(pmem_read || pmem_write)) begin
            mem_active = 1'b0;
            pmem_resp  = 1'b0;
        end else begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_wait   = mem_delay;
                mem_beat   = 0;
                mem_line   = 256'd0;
                if (mem_q.size() > 0) mem_line = mem_q.pop_front();
            end
            if (mem_wait > 0) begin
                pmem_resp = 1'b0;
                mem_wait--;
            end else if (mem_beat < 4) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_line[mem_beat*64 +: 64];
                mem_beat++;
            end else begin
                pmem_resp = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    logic         prev_busy = 1'b0;
    logic         busy;
    int           burst_beats = 0;
    int           last_beat_cyc = -10;
    logic [256:0] exp_resp;
    logic [33:0]  exp_addr;

    always begin
        @(negedge clk);
        if (rst) begin
            prev_busy   = 1'b0;
            burst_beats = 0;
        end else begin
            busy = pmem_read || pmem_write;
            if (busy && !prev_busy) begin
                exp_addr = 34'd0;
                if (exp_addr_q.size() > 0) exp_addr = exp_addr_q.pop_front();
                check("burst_start", 260'({pmem_write, pmem_read, pmem_address}), 260'(exp_addr));
            end
            if (pmem_write && pmem_resp) begin
                if (exp_w_q.size() > 0) check("write_beat", 260'(pmem_wdata), 260'(exp_w_q.pop_front()));
                else check("write_beat_unexpected", 260'(pmem_wdata), 260'(1) << 259);
            end
            if (busy && pmem_resp) begin
                burst_beats++;
                last_beat_cyc = cyc;
            end
            if (!busy && prev_busy) begin
                check("burst_beats", 260'(burst_beats), 260'(4));
                burst_beats = 0;
            end
            if (i_line_resp || d_line_resp) begin
                if (exp_q.size() > 0) begin
                    exp_resp = exp_q.pop_front();
                    if (exp_resp[256])
                        check("d_resp", 260'({d_line_resp, i_line_resp, d_line_rdata}),
                              260'({2'b10, exp_resp[255:0]}));
                    else
                        check("i_resp", 260'({d_line_resp, i_line_resp, i_line_rdata}),
                              260'({2'b01, exp_resp[255:0]}));
                end else begin
                    check("unexpected_resp", 260'({d_line_resp, i_line_resp}), 260'(0));
                end
                check("resp_latency", 260'(cyc), 260'(last_beat_cyc + 1));
            end
            prev_busy = busy;
        end
    end

    // driver tasks
    task automatic wait_i_resp();
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (i_line_resp) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL i_resp_timeout got=none exp=i_line_resp");
        end
        @(posedge clk);
        #1;
        i_line_read = 1'b0;
    endtask

    task automatic wait_d_resp();
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (d_line_resp) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL d_resp_timeout got=none exp=d_line_resp");
        end
        @(posedge clk);
        #1;
        d_line_read  = 1'b0;
        d_line_write = 1'b0;
    endtask

    task automatic i_request(input logic [31:0] addr);
        @(posedge clk);
        #1;
        i_line_address = addr;
        i_line_read    = 1'b1;
        wait_i_resp();
    endtask

    task automatic d_request(input logic [31:0] addr, input logic wr, input logic [255:0] wdata);
        @(posedge clk);
        #1;
        d_line_address = addr;
        d_line_wdata   = wdata;
        d_line_write   = wr;
        d_line_read    = !wr;
        wait_d_resp();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        d_model = 256'd0;
    endtask

    initial begin
        rst            = 1'b1;
        i_line_read    = 1'b1;
        i_line_address = 32'h0000_1234;
        d_line_read    = 1'b0;
        d_line_write   = 1'b0;
        d_line_address = 32'd0;
        d_line_wdata   = 256'd0;

        // reset with icache request pending, then the icache fill
        exp_addr_q.push_back({2'b01, 32'h0000_1220});
        mem_q.push_back(L1);
        exp_q.push_back({1'b0, L1});
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_ctrl", 260'({pmem_read, pmem_write, pmem_address, pmem_wdata,
                                      i_line_resp, d_line_resp}), 260'(0));
            check("reset_i_rdata", 260'(i_line_rdata), 260'(0));
            check("reset_d_rdata", 260'(d_line_rdata), 260'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_release", 260'(pmem_read), 260'(0));
        @(negedge clk);
        check("issue_after_release", 260'(pmem_read), 260'(1));
        wait_i_resp();

        // reset after the third beat of a fill, then replay
        mem_q.push_back(L2);
        mem_q.push_back(L2);
        exp_addr_q.push_back({2'b01, 32'h0000_2000});
        exp_addr_q.push_back({2'b01, 32'h0000_2000});
        exp_q.push_back({1'b0, L2});
        @(posedge clk);
        #1;
        i_line_address = 32'h0000_2010;
        i_line_read    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_i_rdata", 260'(i_line_rdata), 260'(0));
        check("abort_ctrl", 260'({pmem_read, i_line_resp, d_line_resp}), 260'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        d_model = 256'd0;
        wait_i_resp();

        // stalled memory
        mem_delay = 10;
        mem_q.push_back(L3);
        exp_addr_q.push_back({2'b01, 32'h0000_3000});
        exp_q.push_back({1'b0, L3});
        i_request(32'h0000_301F);
        mem_delay = 0;

        // contention, starting from a fresh arbitration pointer
        pulse_reset();
`ifdef PMEM_ARB_RR_EN
        mem_q.push_back(L4); mem_q.push_back(L6); mem_q.push_back(L5);
        exp_addr_q.push_back({2'b01, 32'h0000_4000});
        exp_addr_q.push_back({2'b01, 32'h0000_6000});
        exp_addr_q.push_back({2'b01, 32'h0000_5000});
        exp_q.push_back({1'b1, L4}); exp_q.push_back({1'b0, L6}); exp_q.push_back({1'b1, L5});
`else
        mem_q.push_back(L4); mem_q.push_back(L5); mem_q.push_back(L6);
        exp_addr_q.push_back({2'b01, 32'h0000_4000});
        exp_addr_q.push_back({2'b01, 32'h0000_5000});
        exp_addr_q.push_back({2'b01, 32'h0000_6000});
        exp_q.push_back({1'b1, L4}); exp_q.push_back({1'b1, L5}); exp_q.push_back({1'b0, L6});
`endif
        d_model = L5;
        fork
            begin
                d_request(32'h0000_4004, 1'b0, 256'd0);
                d_request(32'h0000_5008, 1'b0, 256'd0);
            end
            i_request(32'h0000_600C);
        join

        // dcache writeback with read also raised: treated as a write, rdata untouched
        mem_q.push_back(256'd0);
        exp_addr_q.push_back({2'b10, 32'h8000_0040});
        exp_w_q.push_back(WD[63:0]);
        exp_w_q.push_back(WD[127:64]);
        exp_w_q.push_back(WD[191:128]);
        exp_w_q.push_back(WD[255:192]);
        exp_q.push_back({1'b1, d_model});
        @(posedge clk);
        #1;
        d_line_address = 32'h8000_0040;
        d_line_wdata   = WD;
        d_line_write   = 1'b1;
        d_line_read    = 1'b1;
        wait_d_resp();

        repeat (4) @(posedge clk);
        check("queues_drained", 260'({exp_q.size(), exp_addr_q.size(), exp_w_q.size()}), 260'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pmem_line_arbiter.md
# pmem_line_arbiter

Bridges the two L1 caches of the mp4 pipeline to the single physical-memory burst port (`pmem_*`) at the top of `mp4`. It arbitrates between icache line fills and dcache fills or writebacks. It converts each granted 256-bit cache-line transfer into a four-beat, 64-bit burst and returns the assembled line with a one-cycle response pulse to the requesting cache.

## Interface
- No parameters. Line = 256 bits, beat = 64 bits, 4 beats per burst, all fixed.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_line_read` in 1: icache line-fill request; held until `i_line_resp`.
- `i_line_address` in 32: icache line address; bits [4:0] ignored.
- `i_line_rdata` out 256: filled line for icache.
- `i_line_resp` out 1: one-cycle completion pulse to icache.
- `d_line_read` in 1: dcache line-fill request; held until `d_line_resp`.
- `d_line_write` in 1: dcache writeback request; held until `d_line_resp`.
- `d_line_address` in 32: dcache line address; bits [4:0] ignored.
- `d_line_wdata` in 256: writeback line; stable while request is held.
- `d_line_rdata` out 256: filled line for dcache.
- `d_line_resp` out 1: one-cycle completion pulse to dcache.
- `pmem_read` out 1: burst read request.
- `pmem_write` out 1: burst write request.
- `pmem_address` out 32: burst address, always `{addr[31:5],5'b0}`.
- `pmem_wdata` out 64: current write beat.
- `pmem_rdata` in 64: current read beat.
- `pmem_resp` in 1: beat strobe; high for 4 consecutive cycles per burst.

## Operation
- **States:** IDLE, I_READ, D_READ, D_WRITE, DONE.
- **IDLE:**
  - Samples requests and selects one per the arbitration rule (Configuration).
  - Latches the granted address, and `d_line_wdata` for a write.
  - Clears the 2-bit beat counter.
  - Moves to the granted state at the next edge.
- **Simultaneous dcache read and write:** if `d_line_read` and `d_line_write` are both high, the request is treated as a write.
- **I_READ / D_READ:**
  - `pmem_read`=1, `pmem_address`=latched address.
  - On each cycle with `pmem_resp`=1, `pmem_rdata` is stored into line bits [64k+63:64k], where k is the beat counter, and the counter increments.
  - When beat 3 is stored, the state moves to DONE.
- **D_WRITE:**
  - `pmem_write`=1, and `pmem_wdata` = latched line bits [64k+63:64k].
  - k advances on each `pmem_resp` cycle.
  - After beat 3, the state moves to DONE.
- **DONE:**
  - `pmem_read`=`pmem_write`=0.
  - `i_line_resp` or `d_line_resp` is pulsed for exactly one cycle, to the granted cache only.
  - The state returns to IDLE at the next edge.
- **Read data lines:** `*_line_rdata` hold the last filled line for that cache until the next fill for that cache completes. A write leaves `d_line_rdata` unchanged.
- **Stray beats:** `pmem_resp` is ignored in IDLE and DONE.
- **Line address:** the latched address is not re-sampled mid-burst. Changes on the cache inputs during a transfer have no effect.

## Timing
- **Reset values:**
  - All outputs 0, including both 256-bit rdata registers.
  - State IDLE, beat counter 0, round-robin pointer = "icache last granted".
- **Reset mid-burst:** the transfer is abandoned, no resp pulse is issued, and the state returns to IDLE.
- **Issue latency:** a request visible in IDLE in cycle t produces `pmem_read`/`pmem_write` high in cycle t+1.
- **Completion latency:** if the final beat arrives in cycle n, the cache resp pulse occurs in cycle n+1.
- **Burst signal hold:** `pmem_read`/`pmem_write` stay high from issue through the final beat cycle, then drop.
- **Back-to-back transfers:**
  - The cache drops its request in the cycle after resp, which is when the block is back in IDLE. The next grant is therefore evaluated one cycle later.
  - The block must not regrant a request in the same cycle as its resp.
- **Minimum transaction:** 6 cycles from request to resp (IDLE, issue, 4 beats, DONE), given a memory that responds immediately.

## Configuration
- **`PMEM_ARB_RR_EN` defined:** round-robin arbitration.
  - When both caches request in IDLE, the cache not granted last wins.
  - The pointer updates on every grant.
- **`PMEM_ARB_RR_EN` undefined:** fixed priority. Dcache always wins over icache; the pointer logic is not built.
- **Single requester:** with either setting, a lone requester is granted immediately.

## Test plan
- **Reset:** assert `rst` for 2 cycles while `i_line_read`=1 -> all outputs 0 during reset. `pmem_read` rises in the first cycle after reset release plus one.
- **Icache fill:**
  - Stimulus: `i_line_read`, address 0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: `pmem_address`=0x0000_1220, `i_line_rdata`=0x44..44_33..33_22..22_11..11, and `i_line_resp` high for exactly 1 cycle.
- **Dcache writeback:**
  - Stimulus: `d_line_write` at 0x8000_0040 with wdata {D3,D2,D1,D0}.
  - Required: `pmem_wdata` is D0, D1, D2, D3 on successive resp cycles, and `d_line_rdata` is unchanged.
- **Contention:**
  - Stimulus: both caches request in the same cycle, twice in a row.
  - Required with `PMEM_ARB_RR_EN`: dcache, then icache.
  - Required without it: dcache twice before icache is served.
- **Reset mid-burst:** `rst` after beat 2 of a read -> no resp pulse. Replaying the same request completes normally with correct data.
- **Stall memory:** delay `pmem_resp` for 10 cycles -> `pmem_read` is held steady, and resp arrives 1 cycle after the 4th beat.
